// File: rtl/pix_pkg.sv
// Shared types and constants for the pixel packer block.
package pix_pkg;

  localparam int PixWidth  = 12;
  localparam int WordWidth = 16;
  localparam int CntWidth  = 4;   // accumulator fill level, 0..15 between pixels
  localparam int PixCntW   = 24;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    FLUSH
  } state_t;

  // Pixel counter increment that sticks at all-ones.
  function automatic logic [PixCntW-1:0] sat_inc(input logic [PixCntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pix_packer_if.sv
// Pixel-in / word-out stream bundle used around the packer.
interface pix_packer_if;
  import pix_pkg::*;

  logic [PixWidth-1:0]  in_d;
  logic                 in_valid;
  logic [WordWidth-1:0] out_d;
  logic                 out_valid;
  logic                 out_ready;

  // master: pixel source plus word consumer
  modport master (output in_d, in_valid, out_ready, input out_d, out_valid);
  // slave: the packer itself
  modport slave  (input in_d, in_valid, out_ready, output out_d, out_valid);
endinterface

// File: rtl/pix_word_fifo.sv
// Packed-word FIFO; a push into a full FIFO succeeds when a pop happens the same cycle.
module pix_word_fifo #(
  parameter int depth = 4,
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(depth));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head reads as zero when empty so out_d is clean in and after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pix_packer.sv
// Packs 12-bit pixels LSB-first into 16-bit words with frame-level flush.
module pix_packer
  import pix_pkg::*;
#(
  parameter int WordFifoDepth = 4
) (
  input  logic                 pix_clk,
  input  logic                 pix_rst_n,
  input  logic                 pix_frameValid,
  input  logic [PixWidth-1:0]  in_d,
  input  logic                 in_valid,
  output logic [WordWidth-1:0] out_d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_done,
  output logic [PixCntW-1:0]   frame_pixels,
  output logic                 overflow
);

  localparam int SumW = WordWidth + PixWidth;

  state_t               state, state_nxt;
  logic [WordWidth-1:0] acc;
  logic [CntWidth-1:0]  cnt;
  logic [CntWidth:0]    cnt_sum;
  logic [SumW-1:0]      sum;
  logic                 accept, word_rdy, pop, full, empty;
  logic                 flush_go, flush_push, push, drop, frame_start;
  logic [WordWidth-1:0] push_data;

  // Accumulator bits at and above cnt are always zero, so OR-merge is safe.
  assign sum         = {{PixWidth{1'b0}}, acc} | ({{WordWidth{1'b0}}, in_d} << cnt);
  assign cnt_sum     = {1'b0, cnt} + (CntWidth+1)'(PixWidth);
  assign accept      = in_valid && (state == ACTIVE || state == DRAIN);
  assign word_rdy    = accept && cnt_sum[CntWidth];
  assign pop         = out_valid && out_ready;
  assign frame_start = (state == IDLE) && pix_frameValid;
  // Flush waits for a free slot rather than dropping the residual word.
  assign flush_push  = (state == FLUSH) && (cnt != '0) && !full;
  assign flush_go    = (state == FLUSH) && ((cnt == '0) || !full);
  assign push        = (word_rdy && (!full || pop)) || flush_push;
  assign push_data   = flush_push ? acc : sum[WordWidth-1:0];
  assign drop        = word_rdy && full && !pop;
  assign frame_done  = flush_go;
  assign out_valid   = !empty;

  pix_word_fifo #(.depth(WordFifoDepth), .width(WordWidth)) u_fifo (
    .clk       (pix_clk),
    .rst_n     (pix_rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (out_d),
    .full      (full),
    .empty     (empty)
  );

  // State register.
  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Frame sequencing: start, input drain after frame end, residual flush.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pix_frameValid)  state_nxt = ACTIVE;
      ACTIVE:  if (!pix_frameValid) state_nxt = DRAIN;
      DRAIN:   if (!in_valid)       state_nxt = FLUSH;
      FLUSH:   if (flush_go)        state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Accumulator, fill count, pixel counter and sticky overflow.
  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      frame_pixels <= '0;
      overflow     <= 1'b0;
    end else if (frame_start) begin
      acc          <= '0;
      cnt          <= '0;
      frame_pixels <= '0;
      overflow     <= 1'b0;
    end else begin
      if (accept) begin
        frame_pixels <= sat_inc(frame_pixels);
        cnt          <= cnt_sum[CntWidth-1:0];
        if (cnt_sum[CntWidth]) acc <= {{(WordWidth-PixWidth){1'b0}}, sum[SumW-1:WordWidth]};
        else                   acc <= sum[WordWidth-1:0];
      end
      if (drop) overflow <= 1'b1;
      if (flush_go) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pix_packer.sv
// Scoreboard bench for pix_packer: directed frames, monitor compares popped words and frame_done.
module tb_pix_packer;
  import pix_pkg::*;

  logic               pix_clk = 1'b0;
  logic               pix_rst_n = 1'b0;
  logic               pix_frameValid = 1'b0;
  logic               frame_done;
  logic [PixCntW-1:0] frame_pixels;
  logic               overflow;

  pix_packer_if bus ();

  pix_packer #(.WordFifoDepth(4)) dut (
    .pix_clk        (pix_clk),
    .pix_rst_n      (pix_rst_n),
    .pix_frameValid (pix_frameValid),
    .in_d           (bus.in_d),
    .in_valid       (bus.in_valid),
    .out_d          (bus.out_d),
    .out_valid      (bus.out_valid),
    .out_ready      (bus.out_ready),
    .frame_done     (frame_done),
    .frame_pixels   (frame_pixels),
    .overflow       (overflow)
  );

  always #5 pix_clk = ~pix_clk;

  logic [15:0] word_q [$];
  int          fp_q   [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          fd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: compare every popped word and every frame_done against the queues.
  always @(negedge pix_clk) begin
    if (pix_rst_n && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (word_q.size() == 0) begin
        n_bad++;
        $display("FAIL word_extra: got %0h expected no word", bus.out_d);
      end else begin
        logic [15:0] e;
        e = word_q.pop_front();
        if (bus.out_d !== e) begin
          n_bad++;
          $display("FAIL word: got %0h expected %0h", bus.out_d, e);
        end
      end
    end
    if (pix_rst_n && frame_done) begin
      fd_cnt++;
      n_cmp++;
      if (fp_q.size() == 0) begin
        n_bad++;
        $display("FAIL frame_done_extra: got pulse with %0d pixels expected none", frame_pixels);
      end else begin
        int e;
        e = fp_q.pop_front();
        if (frame_pixels !== 24'(e)) begin
          n_bad++;
          $display("FAIL frame_pixels: got %0d expected %0d", frame_pixels, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic send_pix(input logic [11:0] v);
    bus.in_valid = 1'b1;
    bus.in_d     = v;
    tick();
  endtask

  task automatic start_frame();
    pix_frameValid = 1'b1;
    tick();
  endtask

  task automatic wait_fd(input int target, input int budget);
    for (int i = 0; i < budget && fd_cnt < target; i++) tick();
    chk("frame_done_seen", fd_cnt, target);
  endtask

  initial begin
    bus.in_d      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    // reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_d", bus.out_d, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_pixels", frame_pixels, 0);
    chk("rst_overflow", overflow, 0);
    tick();
    pix_rst_n = 1'b1;
    tick();

    // four pixels, three words, no residual
    bus.out_ready = 1'b1;
    word_q.push_back(16'h6123); word_q.push_back(16'h8945); word_q.push_back(16'hABC7);
    fp_q.push_back(4);
    start_frame();
    send_pix(12'h123); send_pix(12'h456); send_pix(12'h789); send_pix(12'hABC);
    bus.in_valid = 1'b0; pix_frameValid = 1'b0;
    tick();
    wait_fd(1, 20);
    repeat (4) tick();
    chk("t1_words_left", word_q.size(), 0);
    chk("t1_frame_pixels_held", frame_pixels, 4);
    chk("t1_overflow", overflow, 0);

    // single pixel, padded word
    word_q.push_back(16'h0FFF);
    fp_q.push_back(1);
    start_frame();
    send_pix(12'hFFF);
    bus.in_valid = 1'b0; pix_frameValid = 1'b0;
    tick();
    wait_fd(2, 20);
    repeat (4) tick();
    chk("t2_words_left", word_q.size(), 0);

    // overflow: 6 words into a depth-4 FIFO with no pops
    bus.out_ready = 1'b0;
    fp_q.push_back(8);
    start_frame();
    for (int i = 1; i <= 8; i++) send_pix(12'(i));
    bus.in_valid = 1'b0; pix_frameValid = 1'b0;
    tick();
    wait_fd(3, 20);
    chk("t3_overflow", overflow, 1);
    chk("t3_out_valid", bus.out_valid, 1);
    chk("t3_head", bus.out_d, 16'h2001);
    word_q.push_back(16'h2001); word_q.push_back(16'h0300);
    word_q.push_back(16'h0040); word_q.push_back(16'h6005);
    bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("t3_words_left", word_q.size(), 0);
    chk("t3_drained", bus.out_valid, 0);

    // pixels arriving during drain; overflow clears at frame start
    word_q.push_back(16'h2A01); word_q.push_back(16'h03B0); word_q.push_back(16'h000C);
    fp_q.push_back(3);
    start_frame();
    chk("t4_overflow_cleared", overflow, 0);
    chk("t4_pixels_cleared", frame_pixels, 0);
    pix_frameValid = 1'b0;
    tick();
    send_pix(12'hA01); send_pix(12'hB02); send_pix(12'hC03);
    bus.in_valid = 1'b0;
    tick();
    wait_fd(4, 20);
    repeat (4) tick();
    chk("t4_words_left", word_q.size(), 0);

    // FIFO full entering flush with a residual
    bus.out_ready = 1'b0;
    start_frame();
    for (int i = 1; i <= 5; i++) send_pix(12'(i));
    send_pix(12'hAB6);
    bus.in_valid = 1'b0; pix_frameValid = 1'b0;
    tick();
    tick();
    repeat (3) tick();
    chk("t5_stuck_in_flush", fd_cnt, 4);
    chk("t5_no_done_while_full", frame_done, 0);
    chk("t5_no_overflow", overflow, 0);
    word_q.push_back(16'h2001); word_q.push_back(16'h0300); word_q.push_back(16'h0040);
    word_q.push_back(16'h6005); word_q.push_back(16'h00AB);
    fp_q.push_back(6);
    bus.out_ready = 1'b1;
    chk("t5_done_not_same_cycle", frame_done, 0);
    tick();
    chk("t5_done_one_after_ready", frame_done, 1);
    wait_fd(5, 20);
    repeat (8) tick();
    chk("t5_words_left", word_q.size(), 0);

    // reset mid-frame discards everything
    bus.out_ready = 1'b0;
    start_frame();
    send_pix(12'h111); send_pix(12'h222); send_pix(12'h333);
    bus.in_valid = 1'b0;
    chk("t6_word_buffered", bus.out_valid, 1);
    pix_rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_out_d", bus.out_d, 0);
    chk("t6_rst_frame_pixels", frame_pixels, 0);
    chk("t6_rst_frame_done", frame_done, 0);
    tick();
    pix_rst_n = 1'b1;
    pix_frameValid = 1'b0;
    bus.in_valid = 1'b1; bus.in_d = 12'h777;
    repeat (4) tick();
    bus.in_valid = 1'b0;
    chk("t6_idle_ignored_valid", bus.out_valid, 0);
    chk("t6_idle_ignored_count", frame_pixels, 0);
    bus.out_ready = 1'b1;
    word_q.push_back(16'h05A5);
    fp_q.push_back(1);
    start_frame();
    send_pix(12'h5A5);
    bus.in_valid = 1'b0; pix_frameValid = 1'b0;
    tick();
    wait_fd(6, 20);
    repeat (4) tick();
    chk("t6_words_left", word_q.size(), 0);
    chk("t6_fp_left", fp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pix_packer.md
PIX_PACKER -- requirements
Module: pix_packer

Interface
REQ-001 SHALL have parameter WordFifoDepth, default 4: depth of the output word FIFO, a power of two and at least 2.
REQ-002 SHALL have port pix_clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 SHALL have port pix_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port pix_frameValid, input, 1 bit: image-sensor frame valid.
REQ-005 SHALL have port in_d, input, 12 bits: pixel from the upstream pixel FIFO.
REQ-006 SHALL have port in_valid, input, 1 bit: in_d holds a pixel this cycle; there is no backpressure, so every valid pixel is taken.
REQ-007 SHALL have port out_d, output, 16 bits: packed word at the FIFO head.
REQ-008 SHALL have port out_valid, output, 1 bit: the word FIFO is not empty.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer pop; a pop happens when out_valid && out_ready.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame is fully flushed.
REQ-011 SHALL have port frame_pixels, output, 24 bits: pixel count of the last frame; valid from frame_done and held until the next frame starts.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a word was dropped.

Function
REQ-013 SHALL pack pixels LSB-first into a bit accumulator: pixel n occupies stream bits [12n+11:12n], and words are stream bits [16k+15:16k].
REQ-014 SHALL keep the accumulator bit count in the range 0..15 between pixels; accepting a pixel adds 12; if the sum is 16 or more, it pushes acc[15:0], shifts the accumulator right by 16 and subtracts 16 from the count, all in the same cycle.
REQ-015 SHALL run a state machine with states IDLE, ACTIVE, DRAIN and FLUSH.
REQ-016 SHALL go IDLE->ACTIVE on pix_frameValid=1; on that edge it clears the accumulator, the count, frame_pixels and overflow.
REQ-017 SHALL go ACTIVE->DRAIN on pix_frameValid=0; the upstream FIFO still drains after the frame ends.
REQ-018 SHALL go DRAIN->FLUSH on the first cycle with in_valid=0.
REQ-019 SHALL go FLUSH->IDLE as follows: if the residual count is above 0, push the zero-padded acc[15:0] once FIFO space exists; in the cycle of leaving it pulses frame_done.
REQ-020 SHALL accept pixels only in ACTIVE and DRAIN; in_valid in IDLE or FLUSH is ignored and not counted.
REQ-021 SHALL increment frame_pixels for every accepted pixel, saturating at 2^24-1.
REQ-022 SHALL, in ACTIVE/DRAIN, drop a word when the FIFO is full and no pop occurs that cycle, and set overflow; the accumulator still advances.
REQ-023 SHALL wait in FLUSH while the FIFO is full; no word is dropped in FLUSH.
REQ-024 SHALL allow a push and a pop in the same cycle when the FIFO is full; the push is not a drop.
REQ-025 SHALL have latency such that a pixel completing a word at edge N gives out_valid=1 after edge N when the FIFO was empty, with no combinational in->out path.
REQ-026 SHALL hold out_d stable while out_valid=1 and out_ready=0.
REQ-027 SHALL ignore a new pix_frameValid=1 seen in DRAIN or FLUSH until IDLE is reached; the frame starts when frameValid is seen high in IDLE.

Reset
REQ-028 SHALL, while pix_rst_n=0: state=IDLE, FIFO empty, out_valid=0, out_d=0, frame_done=0, frame_pixels=0, overflow=0, accumulator and count = 0.
REQ-029 SHALL, on a reset mid-frame, discard all buffered data; the next frame starts clean from IDLE.

Structure
REQ-030 SHALL place the state enum (IDLE/ACTIVE/DRAIN/FLUSH) and the PixWidth=12 and WordWidth=16 constants in shared package pix_pkg.
REQ-031 SHALL place the word FIFO in sub-module pix_word_fifo (parameter depth, width 16, async active-low reset, full/empty outputs, simultaneous push/pop).

Verification
REQ-032 SHALL cover: out_ready=1 with pixels 0x123,0x456,0x789,0xABC -> words 0x6123, 0x8945, 0xABC7; then frameValid low with in_valid low -> frame_done, frame_pixels=4, no extra word.
REQ-033 SHALL cover: a single pixel 0xFFF, then frame end -> one word 0x0FFF, frame_done, frame_pixels=1.
REQ-034 SHALL cover: out_ready=0 with 8 pixels (6 words), depth 4 -> overflow=1, exactly 4 words held; overflow clears at the next frame start.
REQ-035 SHALL cover: 3 pixels arriving in DRAIN after frameValid falls -> all counted, a padded word pushed in FLUSH, frame_pixels=3.
REQ-036 SHALL cover: FIFO full entering FLUSH with a residual -> stays in FLUSH, and frame_done comes one cycle after out_ready rises.
REQ-037 SHALL cover: pix_rst_n pulsed low mid-frame -> outputs at reset values at once, and in_valid is ignored until the next frameValid rise.
